keen_decode_stage: RTL and testbench
====================================

Name: keen_decode_stage

Overview:
- Registered RV32I decode stage: accepts a raw instruction word over a valid/ready handshake.
- Emits register indices, funct fields, instruction format, and the fully sign-extended immediate for all five immediate formats (I, S, B, U, J).
- Generalises the single-format sign-extender to every RV32I format, adds a two-entry skid buffer for full throughput under backpressure, and adds a synchronous flush.
- Sits between fetch and execute.

Parameters:
- XLEN, 32, datapath/immediate output width; must be >= 32.
- ILEN, 32, instruction width; fixed at 32 for RV32I; other values are unsupported (elaboration error).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept.
- in_insn  input  ILEN  raw instruction word.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  downstream accepts.
- out_opcode  output  7  insn[6:0].
- out_rd  output  5  insn[11:7].
- out_rs1  output  5  insn[19:15].
- out_rs2  output  5  insn[24:20].
- out_funct3  output  3  insn[14:12].
- out_funct7  output  7  insn[31:25].
- out_fmt  output  3  R=0, I=1, S=2, B=3, U=4, J=5, unknown=7.
- out_imm  output  XLEN  sign-extended immediate.

Behaviour:
- Reset (async assert, sync deassert):
  - out_valid=0; skid entry empty; in_ready=1.
  - All out_* data registers = 0.
- Format selection by opcode:
  - 0110111/0010111 -> U.
  - 1101111 -> J.
  - 1100111, 0000011, 0010011, 0001111, 1110011 -> I.
  - 1100011 -> B.
  - 0100011 -> S.
  - 0110011 -> R.
  - Anything else -> unknown.
- Immediate generation (sext = replicate bit 31 to XLEN):
  - I: sext(insn[31:20]).
  - S: sext({insn[31:25], insn[11:7]}).
  - B: sext({insn[31], insn[7], insn[30:25], insn[11:8], 0}).
  - U: sext({insn[31:12], 12'b0}).
  - J: sext({insn[31], insn[19:12], insn[20], insn[30:21], 0}).
  - R and unknown: 0.
- Field outputs are raw slices regardless of format; consumers qualify them with out_fmt.
- Decode is combinational on in_insn and registered on acceptance. Latency is 1 cycle: accepted at edge N, visible with out_valid=1 after edge N.
- Handshake:
  - Transfer occurs when valid & ready in the same cycle.
  - in_ready is a register output = skid entry empty; it never depends combinationally on out_ready.
  - out_valid, once asserted, holds, and out_* stay stable until out_ready=1.
- Skid buffer:
  - If input is accepted while the output register holds an entry and out_ready=0, the new decoded entry goes to the skid slot and in_ready drops next cycle.
  - When the output drains, the skid entry moves to output; in_ready=1 next cycle.
  - Order is preserved; no loss or duplication.
- Simultaneous accept and drain with skid empty: output register loads the new entry directly; out_valid stays 1.
- Empty pipe: out_ready is ignored.
- flush:
  - Takes priority over every transfer in that cycle.
  - Next cycle: out_valid=0, skid empty, in_ready=1; the input offered during the flush cycle is dropped.
  - Data registers need not clear.
- Reset mid-transfer: all entries are lost immediately, with no partial output.

Optional Feature:
- Macro: KEEN_DECODE_ILLEGAL_EN.
- When defined:
  - Adds output port out_illegal (1 bit, reset 0), registered and buffered alongside the entry.
  - Set when insn[1:0] != 2'b11, out_fmt = unknown, or insn = 0x00000000.
  - Set for funct3 violations: JALR funct3 != 0, BRANCH funct3 in {2,3}, LOAD funct3 in {3,6,7}, STORE funct3 > 2.
- When undefined: the port is absent and no illegal-detection logic is synthesised; behaviour is otherwise identical.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, fmt=1, rd=1, rs1=0, imm=0xFFFFFFFF.
- 0xFE20AE23 (sw x2,-4(x1)) -> fmt=2, rs1=1, rs2=2, funct3=2, imm=0xFFFFFFFC.
- 0x123452B7 (lui x5,0x12345) -> fmt=4, rd=5, imm=0x12345000; 0x001000EF (jal x1,2048) -> fmt=5, imm=0x00000800.
- Backpressure: out_ready=0, send 0xFFF00093 then 0x123452B7 back-to-back -> in_ready=0 after second; raise out_ready -> both emerge in order over 2 cycles, then in_ready=1.
- Skid full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, no entry emitted; assert rst mid-backpressure -> same, with out_imm=0.
- KEEN_DECODE_ILLEGAL_EN defined: 0x00000000 -> out_illegal=1; 0xFFF00093 -> out_illegal=0.

Source files
------------

// File: rtl/keen_decode_stage_if.sv
// Handshake and decoded-entry bundle between fetch, keen_decode_stage and execute.
// The out_illegal signal exists only when KEEN_DECODE_ILLEGAL_EN is defined.
interface keen_decode_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ILEN = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [ILEN-1:0]   in_insn;
   logic              out_valid;
   logic              out_ready;
   logic [6:0]        out_opcode;
   logic [4:0]        out_rd;
   logic [4:0]        out_rs1;
   logic [4:0]        out_rs2;
   logic [2:0]        out_funct3;
   logic [6:0]        out_funct7;
   logic [2:0]        out_fmt;
   logic [XLEN-1:0]   out_imm;
`ifdef KEEN_DECODE_ILLEGAL_EN
   logic              out_illegal;
`endif

   // Upstream/downstream environment side
   modport master (
      output in_valid, in_insn, out_ready,
      input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_fmt, out_imm
`ifdef KEEN_DECODE_ILLEGAL_EN
      , input out_illegal
`endif
   );

   // Decode stage side
   modport slave (
      input  in_valid, in_insn, out_ready,
      output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_fmt, out_imm
`ifdef KEEN_DECODE_ILLEGAL_EN
      , output out_illegal
`endif
   );
endinterface

// File: rtl/keen_decode_stage.sv
// keen_decode_stage: registered RV32I decode with a two-entry (output + skid)
// buffer and synchronous flush. Optional illegal-instruction flag is enabled
// by defining KEEN_DECODE_ILLEGAL_EN.
module keen_decode_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ILEN = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   keen_decode_stage_if.slave bus
);
   localparam int unsigned FMT_W = 3;
   localparam int unsigned OPC_W = 7;

   localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
   localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
   localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
   localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
   localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
   localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
   localparam logic [FMT_W-1:0] FMT_UNK = 3'd7;

   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
   localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

   // Reject unsupported configurations at elaboration
   generate
      if (ILEN != 32) begin : g_ilen_chk
         $error("keen_decode_stage: ILEN must be 32");
      end
      if (XLEN < 32) begin : g_xlen_chk
         $error("keen_decode_stage: XLEN must be >= 32");
      end
   endgenerate

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [FMT_W-1:0] fmt;
      logic [XLEN-1:0]  imm;
`ifdef KEEN_DECODE_ILLEGAL_EN
      logic             illegal;
`endif
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   logic [31:0]      w_insn;
   logic [FMT_W-1:0] w_fmt;
   logic [31:0]      w_imm32;
   entry_t           w_dec;
   logic             w_accept;
   logic             w_drain;
   state_t           w_state_nxt;
   logic             w_ld_out_dec;
   logic             w_ld_out_skid;
   logic             w_ld_skid;

   state_t           r_state;
   logic             r_out_valid;
   logic             r_in_ready;
   entry_t           r_out;
   entry_t           r_skid;

   assign w_insn = bus.in_insn;

   // Instruction format from opcode
   always_comb begin
      w_fmt = FMT_UNK;
      case (w_insn[6:0])
         OPC_LUI, OPC_AUIPC:                                   w_fmt = FMT_U;
         OPC_JAL:                                              w_fmt = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM: w_fmt = FMT_I;
         OPC_BRANCH:                                           w_fmt = FMT_B;
         OPC_STORE:                                            w_fmt = FMT_S;
         OPC_OP:                                               w_fmt = FMT_R;
         default:                                              w_fmt = FMT_UNK;
      endcase
   end

   // 32-bit immediate per format; widened to XLEN with sign extension below
   always_comb begin
      w_imm32 = 32'h0;
      case (w_fmt)
         FMT_I:   w_imm32 = {{20{w_insn[31]}}, w_insn[31:20]};
         FMT_S:   w_imm32 = {{20{w_insn[31]}}, w_insn[31:25], w_insn[11:7]};
         FMT_B:   w_imm32 = {{19{w_insn[31]}}, w_insn[31], w_insn[7],
                             w_insn[30:25], w_insn[11:8], 1'b0};
         FMT_U:   w_imm32 = {w_insn[31:12], 12'h000};
         FMT_J:   w_imm32 = {{11{w_insn[31]}}, w_insn[31], w_insn[19:12],
                             w_insn[20], w_insn[30:21], 1'b0};
         default: w_imm32 = 32'h0;
      endcase
   end

   // Assemble the decoded entry; field slices are raw regardless of format
   always_comb begin
      w_dec        = '0;
      w_dec.opcode = w_insn[6:0];
      w_dec.rd     = w_insn[11:7];
      w_dec.rs1    = w_insn[19:15];
      w_dec.rs2    = w_insn[24:20];
      w_dec.funct3 = w_insn[14:12];
      w_dec.funct7 = w_insn[31:25];
      w_dec.fmt    = w_fmt;
      w_dec.imm    = XLEN'($signed(w_imm32));
`ifdef KEEN_DECODE_ILLEGAL_EN
      w_dec.illegal = (w_insn[1:0] != 2'b11) || (w_fmt == FMT_UNK) || (w_insn == 32'h0);
      case (w_insn[6:0])
         OPC_JALR:   if (w_insn[14:12] != 3'd0) w_dec.illegal = 1'b1;
         OPC_BRANCH: if (w_insn[14:12] == 3'd2 || w_insn[14:12] == 3'd3) w_dec.illegal = 1'b1;
         OPC_LOAD:   if (w_insn[14:12] == 3'd3 || w_insn[14:12] >= 3'd6) w_dec.illegal = 1'b1;
         OPC_STORE:  if (w_insn[14:12] > 3'd2) w_dec.illegal = 1'b1;
         default:    ;
      endcase
`endif
   end

   assign w_accept = bus.in_valid & r_in_ready;
   assign w_drain  = r_out_valid & bus.out_ready;

   // Occupancy state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Next occupancy and buffer load controls; flush overrides any transfer
   always_comb begin
      w_state_nxt   = r_state;
      w_ld_out_dec  = 1'b0;
      w_ld_out_skid = 1'b0;
      w_ld_skid     = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt  = ST_ONE;
                  w_ld_out_dec = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  w_ld_out_dec = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_ld_skid   = 1'b1;
               end else if (w_drain) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_drain) begin
                  w_state_nxt   = ST_ONE;
                  w_ld_out_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Output/skid registers and registered handshake flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out       <= '0;
         r_skid      <= '0;
      end else begin
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         r_in_ready  <= (w_state_nxt != ST_FULL);
         if (w_ld_out_dec)       r_out <= w_dec;
         else if (w_ld_out_skid) r_out <= r_skid;
         if (w_ld_skid)          r_skid <= w_dec;
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_opcode = r_out.opcode;
   assign bus.out_rd     = r_out.rd;
   assign bus.out_rs1    = r_out.rs1;
   assign bus.out_rs2    = r_out.rs2;
   assign bus.out_funct3 = r_out.funct3;
   assign bus.out_funct7 = r_out.funct7;
   assign bus.out_fmt    = r_out.fmt;
   assign bus.out_imm    = r_out.imm;
`ifdef KEEN_DECODE_ILLEGAL_EN
   assign bus.out_illegal = r_out.illegal;
`endif
endmodule

// File: tb/tb_keen_decode_stage.sv
// Scoreboard bench for keen_decode_stage: accepted instructions push a
// model-decoded entry, a negedge monitor pops and compares on each output
// transfer and checks occupancy and hold-under-stall behaviour.
module tb_keen_decode_stage;
   logic clk;
   logic rst;
   logic flush;

   int checks   = 0;
   int failures = 0;

   keen_decode_stage_if #(.XLEN(32), .ILEN(32)) bus ();

   keen_decode_stage #(.XLEN(32), .ILEN(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [2:0]  fmt;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];

   // Reference decode written from the format/immediate rules with arithmetic shifts
   function automatic exp_t model(input logic [31:0] insn);
      exp_t        e;
      int          s;
      logic [2:0]  f3;
      s = int'(insn);
      f3 = insn[14:12];
      e.opcode = insn[6:0];
      e.rd  = insn[11:7];
      e.rs1 = insn[19:15];
      e.rs2 = insn[24:20];
      e.f3  = f3;
      e.f7  = insn[31:25];
      case (insn[6:0])
         7'h37, 7'h17:                      e.fmt = 3'd4;
         7'h6F:                             e.fmt = 3'd5;
         7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: e.fmt = 3'd1;
         7'h63:                             e.fmt = 3'd3;
         7'h23:                             e.fmt = 3'd2;
         7'h33:                             e.fmt = 3'd0;
         default:                           e.fmt = 3'd7;
      endcase
      case (e.fmt)
         3'd1: e.imm = 32'(s >>> 20);
         3'd2: e.imm = 32'((s >>> 25) <<< 5) | 32'(insn[11:7]);
         3'd3: e.imm = 32'((s >>> 31) <<< 12) | (32'(insn[7]) << 11)
                     | (32'(insn[30:25]) << 5) | (32'(insn[11:8]) << 1);
         3'd4: e.imm = insn & 32'hFFFF_F000;
         3'd5: e.imm = 32'((s >>> 31) <<< 20) | (32'(insn[19:12]) << 12)
                     | (32'(insn[20]) << 11) | (32'(insn[30:21]) << 1);
         default: e.imm = 32'h0;
      endcase
`ifdef KEEN_DECODE_ILLEGAL_EN
      e.ill = (insn[1:0] != 2'b11) || (e.fmt == 3'd7) || (insn == 32'h0)
           || (insn[6:0] == 7'h67 && f3 != 3'd0)
           || (insn[6:0] == 7'h63 && (f3 == 3'd2 || f3 == 3'd3))
           || (insn[6:0] == 7'h03 && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
           || (insn[6:0] == 7'h23 && f3 > 3'd2);
`else
      e.ill = 1'b0;
`endif
      return e;
   endfunction

   function automatic exp_t snap();
      exp_t e;
      e.opcode = bus.out_opcode;
      e.rd  = bus.out_rd;
      e.rs1 = bus.out_rs1;
      e.rs2 = bus.out_rs2;
      e.f3  = bus.out_funct3;
      e.f7  = bus.out_funct7;
      e.fmt = bus.out_fmt;
      e.imm = bus.out_imm;
`ifdef KEEN_DECODE_ILLEGAL_EN
      e.ill = bus.out_illegal;
`else
      e.ill = 1'b0;
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue side: record every accepted instruction; flush drops everything
   always @(posedge clk) begin
      if (!rst) begin
         if (flush) exp_q.delete();
         else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_insn));
      end
   end

   // Monitor: occupancy, hold under stall, and in-order data on each drain
   exp_t prev_out;
   logic prev_stall = 1'b0;
   always @(negedge clk) begin
      exp_t cur;
      exp_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         cur = snap();
         checks++;
         if (bus.out_valid !== (exp_q.size() != 0) || bus.in_ready !== (exp_q.size() < 2)) begin
            failures++;
            $display("FAIL occupancy: out_valid=%0b in_ready=%0b model_entries=%0d",
                     bus.out_valid, bus.in_ready, exp_q.size());
         end
         if (prev_stall) begin
            checks++;
            if (bus.out_valid !== 1'b1 || cur !== prev_out) begin
               failures++;
               $display("FAIL hold: out_valid=%0b got %h required %h", bus.out_valid, cur, prev_out);
            end
         end
         if (!flush && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL scoreboard: unexpected output %h", cur);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  failures++;
                  $display("FAIL entry: got %h required %h", cur, e);
               end
            end
         end
         prev_stall = !flush && bus.out_valid && !bus.out_ready;
         prev_out   = cur;
      end
   end

   // Single instruction with out_ready=1; checks format and immediate one cycle later
   task automatic send_chk(input logic [31:0] insn, input logic [2:0] fmt, input logic [31:0] imm);
      bus.in_valid  = 1'b1;
      bus.in_insn   = insn;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("lat_valid", 32'(bus.out_valid), 32'd1);
      chk("fmt", 32'(bus.out_fmt), 32'(fmt));
      chk("imm", bus.out_imm, imm);
   endtask

   // Fill output and skid with addi then lui under backpressure
   task automatic fill_two();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_insn   = 32'hFFF0_0093;
      step();
      bus.in_insn   = 32'h1234_52B7;
      step();
      bus.in_valid  = 1'b0;
   endtask

   logic [31:0] r32;
   logic [6:0]  opc_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                                 7'h0F, 7'h73, 7'h63, 7'h23, 7'h33};

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_insn   = 32'h0;
      bus.out_ready = 1'b0;
      step();
      step();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_imm",       bus.out_imm,        32'd0);
      chk("rst_fmt",       32'(bus.out_fmt),   32'd0);
      chk("rst_opcode",    32'(bus.out_opcode), 32'd0);
      rst = 1'b0;
      step();

      // Directed decode vectors
      send_chk(32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF);
      chk("addi_rd",  32'(bus.out_rd),  32'd1);
      chk("addi_rs1", 32'(bus.out_rs1), 32'd0);
      send_chk(32'hFE20_AE23, 3'd2, 32'hFFFF_FFFC);
      chk("sw_rs1", 32'(bus.out_rs1),    32'd1);
      chk("sw_rs2", 32'(bus.out_rs2),    32'd2);
      chk("sw_f3",  32'(bus.out_funct3), 32'd2);
      send_chk(32'h1234_52B7, 3'd4, 32'h1234_5000);
      chk("lui_rd", 32'(bus.out_rd), 32'd5);
      send_chk(32'h0010_00EF, 3'd5, 32'h0000_0800);
      send_chk(32'h0000_0033, 3'd0, 32'h0000_0000);
`ifdef KEEN_DECODE_ILLEGAL_EN
      send_chk(32'h0000_0000, 3'd7, 32'h0000_0000);
      chk("illegal_zero", 32'(bus.out_illegal), 32'd1);
      send_chk(32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF);
      chk("illegal_addi", 32'(bus.out_illegal), 32'd0);
`endif
      step();

      // Backpressure: both entries emerge in order, then in_ready recovers
      fill_two();
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("bp_first_imm",    bus.out_imm,       32'hFFFF_FFFF);
      bus.out_ready = 1'b1;
      step();
      chk("bp_second_imm",   bus.out_imm,        32'h1234_5000);
      chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready_hi",  32'(bus.in_ready),  32'd1);
      step();
      chk("bp_drained", 32'(bus.out_valid), 32'd0);

      // Flush with skid full plus an offered input
      fill_two();
      bus.in_valid = 1'b1;
      bus.in_insn  = 32'h0010_00EF;
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("flush_full_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_full_ready", 32'(bus.in_ready),  32'd1);
      step();
      chk("flush_full_no_emit", 32'(bus.out_valid), 32'd0);

      // Flush while the stage could accept: offered input is dropped
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_insn   = 32'hFFF0_0093;
      step();
      bus.in_insn = 32'h1234_52B7;
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_one_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_one_ready", 32'(bus.in_ready),  32'd1);

      // Asynchronous reset during backpressure
      fill_two();
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_ready", 32'(bus.in_ready),  32'd1);
      chk("arst_imm",   bus.out_imm,        32'd0);
      step();
      rst = 1'b0;
      step();

      // Randomized traffic with random backpressure and occasional flush
      for (int i = 0; i < 3000; i++) begin
         r32 = $urandom;
         if ($urandom_range(0, 4) != 0)
            r32[6:0] = opc_tab[$urandom_range(0, 10)];
         bus.in_insn   = r32;
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         flush         = ($urandom_range(0, 40) == 0);
         step();
      end
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) step();
      chk("final_drain", 32'(exp_q.size()), 32'd0);
      chk("final_valid", 32'(bus.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
